// File: rtl/sbox_affine_seq.sv
// sbox_affine_seq: drives one shared single-bit affine unit (bitmod) over
// bit indices 0..7 and reassembles the returned bits into the forward S-box
// affine byte. The result is handed off over a valid/ready pair.
module sbox_affine_seq #(
   parameter int BITMOD_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [2:0] bm_ibit,
   output logic [7:0] bm_idata,
   input  logic       bm_obit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int LAST = BITMOD_LATENCY - 1;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] operand_q, operand_d;
   logic [7:0] result_q, result_d;

   // Capture pipeline: one (valid, index) entry per issued bit, aligned so
   // that the last stage lines up with the matching bit on bm_obit.
   logic [LAST:0] cap_vld_q;
   logic [2:0]    cap_idx_q [BITMOD_LATENCY];

   logic issue;
   logic cnt_last;
   logic cap_fire;
   logic last_cap;

   assign issue    = (state_q == S_ISSUE);
   assign cnt_last = (cnt_q == 3'd7);
   assign cap_fire = cap_vld_q[LAST];
   assign last_cap = cap_fire && (cap_idx_q[LAST] == 3'd7);

   // Control, operand, counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         operand_q <= 8'd0;
         result_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         operand_q <= operand_d;
         result_q  <= result_d;
      end
   end

   // First capture stage is fed by the index being presented this cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_vld_q[0] <= 1'b0;
         cap_idx_q[0] <= 3'd0;
      end else begin
         cap_vld_q[0] <= issue;
         cap_idx_q[0] <= cnt_q;
      end
   end

   // Remaining capture stages just delay the entry by one cycle each.
   for (genvar gi = 1; gi < BITMOD_LATENCY; gi++) begin : g_cap
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cap_vld_q[gi] <= 1'b0;
            cap_idx_q[gi] <= 3'd0;
         end else begin
            cap_vld_q[gi] <= cap_vld_q[gi-1];
            cap_idx_q[gi] <= cap_idx_q[gi-1];
         end
      end
   end

   // Next-state logic; bm_obit only touches the result when an entry emerges.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      operand_d = operand_q;
      result_d  = result_q;

      if (cap_fire) begin
         result_d[cap_idx_q[LAST]] = bm_obit;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               operand_d = in_data;
               result_d  = 8'd0;
               cnt_d     = 3'd0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cnt_last) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DRAIN: begin
            // No new issues, so index 7 is the final entry in flight.
            if (last_cap) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               cnt_d   = 3'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = result_q;
   assign bm_ibit   = cnt_q;
   assign bm_idata  = operand_q;

endmodule

// File: tb/tb_sbox_affine_seq.sv
// Bench for sbox_affine_seq: two instances (bitmod latency 1 and 3), each
// paired with a behavioural bitmod that returns random garbage whenever no
// index is legitimately being issued.
module tb_sbox_affine_seq;

   localparam logic [7:0] AFF_C = 8'h63;

   logic       clk;
   logic       rst_n;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [7:0] in_data   [2];
   logic [2:0] bm_ibit   [2];
   logic [7:0] bm_idata  [2];
   logic       bm_obit   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [7:0] out_data  [2];
   logic       busy      [2];

   int n_cmp = 0;
   int n_mis = 0;

   // Single bit of the affine transform, as bitmod computes it.
   function automatic logic bit_ref(input logic [7:0] a, input logic [2:0] i);
      logic r;
      r = a[i] ^ a[3'(i + 3'd4)] ^ a[3'(i + 3'd5)] ^ a[3'(i + 3'd6)] ^ a[3'(i + 3'd7)] ^ AFF_C[i];
      return r;
   endfunction

   // Whole-byte reference: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   function automatic logic [7:0] affine_ref(input logic [7:0] x);
      logic [7:0] acc;
      acc = x;
      for (int r = 1; r <= 4; r++) begin
         acc = acc ^ ((x << r) | (x >> (8 - r)));
      end
      return acc ^ AFF_C;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [LAT-1:0] pipe_q;
      int             left_q;

      sbox_affine_seq #(.BITMOD_LATENCY(LAT)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid[gi]),
         .in_ready (in_ready[gi]),
         .in_data  (in_data[gi]),
         .bm_ibit  (bm_ibit[gi]),
         .bm_idata (bm_idata[gi]),
         .bm_obit  (bm_obit[gi]),
         .out_valid(out_valid[gi]),
         .out_ready(out_ready[gi]),
         .out_data (out_data[gi]),
         .busy     (busy[gi])
      );

      // bitmod model: real bit only for the 8 cycles after an acceptance.
      always @(posedge clk) begin
         if (!rst_n) left_q <= 0;
         else if (in_valid[gi] && in_ready[gi]) left_q <= 8;
         else if (left_q > 0) left_q <= left_q - 1;
         pipe_q[0] <= (left_q > 0) ? bit_ref(bm_idata[gi], bm_ibit[gi]) : 1'($urandom);
         for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
      assign bm_obit[gi] = pipe_q[LAT-1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after the acceptance edge; checks issue sequence, latency,
   // result, stability under backpressure and the output handshake.
   task automatic wait_result(input int sel, input logic [7:0] d, input logic [7:0] expv,
                              input int exp_lat, input int hold);
      int lat;
      logic [7:0] res;
      lat = 0;
      while (!out_valid[sel] && lat < 60) begin
         chk("bm_ibit", bm_ibit[sel], (lat > 7) ? 7 : lat);
         chk("bm_idata", bm_idata[sel], d);
         step();
         lat++;
      end
      chk("latency", lat, exp_lat);
      res = out_data[sel];
      chk("out_data", res, expv);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", out_valid[sel], 1);
         chk("hold_data", out_data[sel], res);
      end
      out_ready[sel] = 1'b1;
      step();
      out_ready[sel] = 1'b0;
      chk("valid_drop", out_valid[sel], 0);
      chk("ready_back", in_ready[sel], 1);
      $display("txn dut%0d in=%02h out=%02h exp=%02h lat=%0d hold=%0d", sel, d, res, expv, lat, hold);
   endtask

   task automatic send(input int sel, input logic [7:0] d, input logic [7:0] expv,
                       input int exp_lat, input int hold);
      int t;
      in_valid[sel] = 1'b1;
      in_data[sel]  = d;
      t = 0;
      while (!in_ready[sel] && t < 50) begin
         step();
         t++;
      end
      chk("accept_wait", in_ready[sel], 1);
      step();
      in_valid[sel] = 1'b0;
      wait_result(sel, d, expv, exp_lat, hold);
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      logic [7:0] res_bb [2];
      int tin [2];
      int tout [2];
      int n_in, n_out, t;
      logic hs_in, hs_out;
      logic [7:0] rnd;

      vecs[0] = '{8'h00, 8'h63};
      vecs[1] = '{8'h01, 8'h7C};
      vecs[2] = '{8'hFF, 8'h9C};
      vecs[3] = '{8'hCA, 8'hED};
      vecs[4] = '{8'h02, 8'h5D};

      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         in_data[s]   = 8'h00;
         out_ready[s] = 1'b0;
      end
      repeat (3) step();
      rst_n = 1'b1;
      step();
      for (int s = 0; s < 2; s++) begin
         chk("rst_in_ready", in_ready[s], 1);
         chk("rst_busy", busy[s], 0);
         chk("rst_out_valid", out_valid[s], 0);
         chk("rst_out_data", out_data[s], 0);
         chk("rst_bm_ibit", bm_ibit[s], 0);
         chk("rst_bm_idata", bm_idata[s], 0);
      end

      // Table vectors on the latency-1 instance.
      for (int v = 0; v < 5; v++) send(0, vecs[v].din, vecs[v].dout, 9, 0);

      // Back-to-back 01, FF with out_ready tied high.
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 8'h01;
      n_in = 0;
      n_out = 0;
      for (int c = 0; c < 60 && n_out < 2; c++) begin
         hs_in  = in_valid[0] && in_ready[0];
         hs_out = out_valid[0] && out_ready[0];
         if (hs_out) begin
            res_bb[n_out] = out_data[0];
            tout[n_out] = c;
            n_out++;
         end
         if (hs_in && n_in < 2) begin
            tin[n_in] = c;
            n_in++;
         end
         step();
         if (hs_in) begin
            if (n_in == 1) in_data[0] = 8'hFF;
            else in_valid[0] = 1'b0;
         end
      end
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      chk("bb_count", n_out, 2);
      if (n_out == 2) begin
         chk("bb_first", res_bb[0], 8'h7C);
         chk("bb_second", res_bb[1], 8'h9C);
         chk("bb_out_spacing", tout[1] - tout[0], 11);
         chk("bb_in_spacing", tin[1] - tin[0], 11);
         $display("txn dut0 back-to-back out=%02h,%02h spacing=%0d", res_bb[0], res_bb[1], tout[1] - tout[0]);
      end

      // Backpressure: 20 cycles in DONE with 02 pending on the input.
      step();
      chk("bp_idle", in_ready[0], 1);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h01;
      step();
      in_data[0] = 8'h02;
      t = 0;
      while (!out_valid[0] && t < 40) begin
         step();
         t++;
      end
      chk("bp_result", out_data[0], 8'h7C);
      for (int h = 0; h < 20; h++) begin
         step();
         chk("bp_valid", out_valid[0], 1);
         chk("bp_data", out_data[0], 8'h7C);
         chk("bp_in_ready", in_ready[0], 0);
      end
      out_ready[0] = 1'b1;
      step();
      out_ready[0] = 1'b0;
      chk("bp_release_idle", in_ready[0], 1);
      chk("bp_release_valid", out_valid[0], 0);
      step();
      chk("bp_accept_busy", busy[0], 1);
      chk("bp_accept_ready", in_ready[0], 0);
      in_valid[0] = 1'b0;
      wait_result(0, 8'h02, 8'h5D, 9, 0);

      // Reset during ISSUE at index 4.
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hA5;
      step();
      in_valid[0] = 1'b0;
      t = 0;
      while (bm_ibit[0] != 3'd4 && t < 20) begin
         step();
         t++;
      end
      chk("mid_issue_idx", bm_ibit[0], 4);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_in_ready", in_ready[0], 1);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_out_valid", out_valid[0], 0);
      chk("mid_rst_out_data", out_data[0], 0);
      chk("mid_rst_bm_ibit", bm_ibit[0], 0);
      chk("mid_rst_bm_idata", bm_idata[0], 0);
      for (int h = 0; h < 6; h++) begin
         step();
         chk("idle_out_data", out_data[0], 0);
         chk("idle_out_valid", out_valid[0], 0);
      end
      send(0, 8'h00, 8'h63, 9, 0);

      // Latency-3 instance.
      send(1, 8'h01, 8'h7C, 11, 0);
      for (int r = 0; r < 4; r++) begin
         rnd = 8'($urandom);
         send(1, rnd, affine_ref(rnd), 11, int'($urandom_range(0, 2)));
      end

      // Randomized bytes and backpressure against the reference model.
      for (int r = 0; r < 25; r++) begin
         rnd = 8'($urandom);
         send(0, rnd, affine_ref(rnd), 9, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
